sram_1p_march_bist_ctrl: RTL and testbench

March C- BIST controller for the single-port bm/bist SRAM macros (default 1024x32). Drives the macro's A_BIST_* port and checks A_DOUT. On START it takes over the array, runs the full march, captures first-fail diagnostics and a fail count, then releases the array. Sits beside the macro in the SoC test wrapper. Software or JTAG starts it and reads the status.

---
 rtl/sram_1p_march_bist_ctrl_pkg.sv | 44 ++++
 rtl/sram_1p_march_bist_ctrl_if.sv | 29 ++
 rtl/sram_bist_march_seq.sv | 60 ++++++
 rtl/sram_1p_march_bist_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sram_1p_march_bist_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_1p_march_bist_ctrl_pkg.sv
// March C- BIST shared definitions: FSM states, the march table and helpers.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic is_write;
        logic data;      // 0 -> all zeros word, 1 -> all ones word
    } march_op_t;

    localparam int C_NUM_ELEMS = 6;
    localparam logic [2:0] C_LAST_ELEM = 3'(C_NUM_ELEMS - 1);

    // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0).
    // Index [elem] for the per-element tables, [elem][op] for the per-op tables.
    localparam logic [C_NUM_ELEMS-1:0] C_ELEM_DOWN    = 6'b011000;
    localparam logic [C_NUM_ELEMS-1:0] C_ELEM_TWO_OPS = 6'b011110;
    localparam logic [C_NUM_ELEMS-1:0][1:0] C_OP_IS_WRITE =
        {2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    localparam logic [C_NUM_ELEMS-1:0][1:0] C_OP_DATA =
        {2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

    function automatic march_op_t march_op(input logic [2:0] elem, input logic op);
        march_op_t m;
        m.is_write = C_OP_IS_WRITE[elem][op];
        m.data     = C_OP_DATA[elem][op];
        return m;
    endfunction

    function automatic logic elem_is_down(input logic [2:0] elem);
        return C_ELEM_DOWN[elem];
    endfunction

    // Index of the final op inside an element (0 for single-op elements).
    function automatic logic elem_last_op(input logic [2:0] elem);
        return C_ELEM_TWO_OPS[elem];
    endfunction

endpackage

// File: rtl/sram_1p_march_bist_ctrl_if.sv
// Macro-side BIST port bundle between the controller (master) and the SRAM macro (slave).
// Protocol: A_BIST_MEN high marks an op cycle; with it exactly one of A_BIST_WEN /
// A_BIST_REN is high. A_DOUT is valid in the cycle after a REN op. There is no
// backpressure: the macro accepts one op every cycle.
interface sram_1p_march_bist_ctrl_if #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 10
);
    logic                    A_BIST_EN;
    logic                    A_BIST_MEN;
    logic                    A_BIST_WEN;
    logic                    A_BIST_REN;
    logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
    logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
    logic [P_DATA_WIDTH-1:0] A_BIST_BM;
    logic [P_DATA_WIDTH-1:0] A_DOUT;

    modport master (
        output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
        output A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
        input  A_DOUT
    );

    modport slave (
        input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
        input  A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
        output A_DOUT
    );
endinterface

// File: rtl/sram_bist_march_seq.sv
// March position sequencer: holds {elem, op, addr} and steps it on each advance strobe.
// After the final op it wraps back to E0 op0 @0, ready for the next run.
module sram_bist_march_seq
    import sram_bist_pkg::*;
#(
    parameter int P_ADDR_WIDTH = 10
) (
    input  logic                    A_BIST_CLK,
    input  logic                    A_BIST_RST_N,
    input  logic                    advance,
    output logic [2:0]              elem,
    output logic                    op,
    output logic [P_ADDR_WIDTH-1:0] addr,
    output logic                    last_op
);
    localparam logic [P_ADDR_WIDTH-1:0] C_ADDR_MAX = '1;

    logic [2:0]              elem_q;
    logic                    op_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic                    down;
    logic                    op_end;
    logic                    addr_end;

    // Decode where the current position sits inside its element and the whole march.
    always_comb begin
        down     = elem_is_down(elem_q);
        op_end   = (op_q == elem_last_op(elem_q));
        addr_end = down ? (addr_q == '0) : (addr_q == C_ADDR_MAX);
        last_op  = op_end && addr_end && (elem_q == C_LAST_ELEM);
    end

    // Step op, then address, then element; the next element starts at its own end address.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
        if (!A_BIST_RST_N) begin
            elem_q <= '0;
            op_q   <= 1'b0;
            addr_q <= '0;
        end else if (advance) begin
            if (!op_end) begin
                op_q <= 1'b1;
            end else begin
                op_q <= 1'b0;
                if (!addr_end) begin
                    addr_q <= down ? addr_q - P_ADDR_WIDTH'(1) : addr_q + P_ADDR_WIDTH'(1);
                end else if (elem_q == C_LAST_ELEM) begin
                    elem_q <= '0;
                    addr_q <= '0;
                end else begin
                    elem_q <= elem_q + 3'd1;
                    addr_q <= elem_is_down(elem_q + 3'd1) ? C_ADDR_MAX : '0;
                end
            end
        end
    end

    assign elem = elem_q;
    assign op   = op_q;
    assign addr = addr_q;
endmodule

// File: rtl/sram_1p_march_bist_ctrl.sv
// March C- BIST controller: FSM, registered macro-side outputs, 1-deep read compare
// pipe and first-fail / fail-count logging.
module sram_1p_march_bist_ctrl
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 10,
    parameter int P_FCNT_WIDTH = 8
) (
    input  logic                    A_BIST_CLK,
    input  logic                    A_BIST_RST_N,
    input  logic                    START,
    sram_1p_march_bist_ctrl_if.master bist,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    FAIL,
    output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [2:0]              FAIL_ELEM,
    output logic [P_DATA_WIDTH-1:0] FAIL_BITS,
    output logic [P_FCNT_WIDTH-1:0] FAIL_CNT,
    output state_t                  DBG_STATE
);
    state_t                  state_q, state_d;
    logic                    issue;
    logic                    start_clear;
    logic [2:0]              seq_elem;
    logic                    seq_op;
    logic [P_ADDR_WIDTH-1:0] seq_addr;
    logic                    seq_last;
    march_op_t               cur_op;

    logic                    men_q, wen_q, ren_q, data_q, last_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0] din_q, bm_q;
    logic [2:0]              elem_q;

    logic                    pipe_vld_q, pipe_exp_q;
    logic [P_ADDR_WIDTH-1:0] pipe_addr_q;
    logic [2:0]              pipe_elem_q;
    logic [P_DATA_WIDTH-1:0] diff;
    logic                    miscmp;

    logic                    fail_q;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]              fail_elem_q;
    logic [P_DATA_WIDTH-1:0] fail_bits_q;
    logic [P_FCNT_WIDTH-1:0] fail_cnt_q;

    sram_bist_march_seq #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_seq (
        .A_BIST_CLK   (A_BIST_CLK),
        .A_BIST_RST_N (A_BIST_RST_N),
        .advance      (issue),
        .elem         (seq_elem),
        .op           (seq_op),
        .addr         (seq_addr),
        .last_op      (seq_last)
    );

    // State register.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
        if (!A_BIST_RST_N) state_q <= ST_IDLE;
        else               state_q <= state_d;
    end

    // Next state; an op is issued on the START edge and on every RUN edge until the last op is out.
    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        start_clear = 1'b0;
        cur_op      = march_op(seq_elem, seq_op);
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d     = ST_RUN;
                    issue       = 1'b1;
                    start_clear = 1'b1;
                end
            end
            ST_RUN: begin
                if (last_q) state_d = ST_DRAIN;
                else        issue   = 1'b1;
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Macro-side output registers; all zero outside op cycles.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
        if (!A_BIST_RST_N) begin
            men_q  <= 1'b0;
            wen_q  <= 1'b0;
            ren_q  <= 1'b0;
            data_q <= 1'b0;
            last_q <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
            bm_q   <= '0;
            elem_q <= '0;
        end else begin
            men_q  <= issue;
            wen_q  <= issue & cur_op.is_write;
            ren_q  <= issue & ~cur_op.is_write;
            data_q <= issue & cur_op.data;
            last_q <= issue & seq_last;
            addr_q <= issue ? seq_addr : '0;
            din_q  <= (issue & cur_op.is_write) ? {P_DATA_WIDTH{cur_op.data}} : '0;
            bm_q   <= (issue & cur_op.is_write) ? '1 : '0;
            elem_q <= issue ? seq_elem : '0;
        end
    end

    // Compare pipe: remembers what the read in flight should return.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
        if (!A_BIST_RST_N) begin
            pipe_vld_q  <= 1'b0;
            pipe_exp_q  <= 1'b0;
            pipe_addr_q <= '0;
            pipe_elem_q <= '0;
        end else begin
            pipe_vld_q  <= ren_q;
            pipe_exp_q  <= data_q;
            pipe_addr_q <= addr_q;
            pipe_elem_q <= elem_q;
        end
    end

    assign diff   = bist.A_DOUT ^ {P_DATA_WIDTH{pipe_exp_q}};
    assign miscmp = pipe_vld_q && (diff != '0);

    // Fail log: first-fail capture, sticky flag, saturating per-read counter; cleared on START.
    always_ff @(posedge A_BIST_CLK or negedge A_BIST_RST_N) begin
        if (!A_BIST_RST_N) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bits_q <= '0;
            fail_cnt_q  <= '0;
        end else if (start_clear) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            fail_bits_q <= '0;
            fail_cnt_q  <= '0;
        end else if (miscmp) begin
            if (!fail_q) begin
                fail_addr_q <= pipe_addr_q;
                fail_elem_q <= pipe_elem_q;
                fail_bits_q <= diff;
            end
            fail_q <= 1'b1;
            if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + P_FCNT_WIDTH'(1);
        end
    end

    assign bist.A_BIST_EN   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bist.A_BIST_MEN  = men_q;
    assign bist.A_BIST_WEN  = wen_q;
    assign bist.A_BIST_REN  = ren_q;
    assign bist.A_BIST_ADDR = addr_q;
    assign bist.A_BIST_DIN  = din_q;
    assign bist.A_BIST_BM   = bm_q;

    assign BUSY      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign DONE      = (state_q == ST_DONE);
    assign FAIL      = fail_q;
    assign FAIL_ADDR = fail_addr_q;
    assign FAIL_ELEM = fail_elem_q;
    assign FAIL_BITS = fail_bits_q;
    assign FAIL_CNT  = fail_cnt_q;
    assign DBG_STATE = state_q;
endmodule

// File: tb/tb_sram_1p_march_bist_ctrl.sv
// Bench for the March C- BIST controller: three DUTs (N=1024, 4, 2) share one
// behavioural SRAM model with selectable faults; an expected-op queue is filled
// from an independent march description and drained cycle by cycle.
module tb_sram_1p_march_bist_ctrl;
    import sram_bist_pkg::*;

    logic clk, rst_n, start;
    int   sel;
    int   fault_mode;
    int   n_vec, n_err;
    logic [31:0] mem [1024];
    logic [31:0] mem_dout;
    logic [11:0] exp_q [$];

    sram_1p_march_bist_ctrl_if #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(10)) ifa ();
    sram_1p_march_bist_ctrl_if #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(2))  ifb ();
    sram_1p_march_bist_ctrl_if #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(1))  ifc ();

    logic a_busy, a_done, a_fail; logic [9:0] a_fail_addr; logic [2:0] a_fail_elem;
    logic [31:0] a_fail_bits; logic [7:0] a_fail_cnt; state_t a_dbg;
    logic b_busy, b_done, b_fail; logic [1:0] b_fail_addr; logic [2:0] b_fail_elem;
    logic [31:0] b_fail_bits; logic [7:0] b_fail_cnt; state_t b_dbg;
    logic c_busy, c_done, c_fail; logic [0:0] c_fail_addr; logic [2:0] c_fail_elem;
    logic [31:0] c_fail_bits; logic [7:0] c_fail_cnt; state_t c_dbg;
    logic a_start, b_start, c_start;

    assign a_start = start && (sel == 0);
    assign b_start = start && (sel == 1);
    assign c_start = start && (sel == 2);
    assign ifa.A_DOUT = mem_dout;
    assign ifb.A_DOUT = mem_dout;
    assign ifc.A_DOUT = mem_dout;

    sram_1p_march_bist_ctrl #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(10), .P_FCNT_WIDTH(8)) dut_a (
        .A_BIST_CLK(clk), .A_BIST_RST_N(rst_n), .START(a_start), .bist(ifa),
        .BUSY(a_busy), .DONE(a_done), .FAIL(a_fail), .FAIL_ADDR(a_fail_addr),
        .FAIL_ELEM(a_fail_elem), .FAIL_BITS(a_fail_bits), .FAIL_CNT(a_fail_cnt), .DBG_STATE(a_dbg));
    sram_1p_march_bist_ctrl #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(2), .P_FCNT_WIDTH(8)) dut_b (
        .A_BIST_CLK(clk), .A_BIST_RST_N(rst_n), .START(b_start), .bist(ifb),
        .BUSY(b_busy), .DONE(b_done), .FAIL(b_fail), .FAIL_ADDR(b_fail_addr),
        .FAIL_ELEM(b_fail_elem), .FAIL_BITS(b_fail_bits), .FAIL_CNT(b_fail_cnt), .DBG_STATE(b_dbg));
    sram_1p_march_bist_ctrl #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(1), .P_FCNT_WIDTH(8)) dut_c (
        .A_BIST_CLK(clk), .A_BIST_RST_N(rst_n), .START(c_start), .bist(ifc),
        .BUSY(c_busy), .DONE(c_done), .FAIL(c_fail), .FAIL_ADDR(c_fail_addr),
        .FAIL_ELEM(c_fail_elem), .FAIL_BITS(c_fail_bits), .FAIL_CNT(c_fail_cnt), .DBG_STATE(c_dbg));

    // Selected-DUT view
    logic v_en, v_men, v_wen, v_ren, v_busy, v_done, v_fail;
    logic [9:0] v_addr, v_fail_addr; logic [2:0] v_fail_elem;
    logic [31:0] v_din, v_bm, v_fail_bits; logic [7:0] v_fail_cnt; state_t v_dbg;
    logic [133:0] v_all;

    always_comb begin
        v_en = ifa.A_BIST_EN; v_men = ifa.A_BIST_MEN; v_wen = ifa.A_BIST_WEN; v_ren = ifa.A_BIST_REN;
        v_addr = ifa.A_BIST_ADDR; v_din = ifa.A_BIST_DIN; v_bm = ifa.A_BIST_BM;
        v_busy = a_busy; v_done = a_done; v_fail = a_fail; v_fail_addr = a_fail_addr;
        v_fail_elem = a_fail_elem; v_fail_bits = a_fail_bits; v_fail_cnt = a_fail_cnt; v_dbg = a_dbg;
        case (sel)
            1: begin
                v_en = ifb.A_BIST_EN; v_men = ifb.A_BIST_MEN; v_wen = ifb.A_BIST_WEN; v_ren = ifb.A_BIST_REN;
                v_addr = 10'(ifb.A_BIST_ADDR); v_din = ifb.A_BIST_DIN; v_bm = ifb.A_BIST_BM;
                v_busy = b_busy; v_done = b_done; v_fail = b_fail; v_fail_addr = 10'(b_fail_addr);
                v_fail_elem = b_fail_elem; v_fail_bits = b_fail_bits; v_fail_cnt = b_fail_cnt; v_dbg = b_dbg;
            end
            2: begin
                v_en = ifc.A_BIST_EN; v_men = ifc.A_BIST_MEN; v_wen = ifc.A_BIST_WEN; v_ren = ifc.A_BIST_REN;
                v_addr = 10'(ifc.A_BIST_ADDR); v_din = ifc.A_BIST_DIN; v_bm = ifc.A_BIST_BM;
                v_busy = c_busy; v_done = c_done; v_fail = c_fail; v_fail_addr = 10'(c_fail_addr);
                v_fail_elem = c_fail_elem; v_fail_bits = c_fail_bits; v_fail_cnt = c_fail_cnt; v_dbg = c_dbg;
            end
            default: ;
        endcase
        v_all = {v_en, v_men, v_wen, v_ren, v_addr, v_din, v_bm, v_busy, v_done, v_fail,
                 v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt};
    end

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM model: masked write, registered read with optional fault
    function automatic logic [31:0] fault_read(input logic [9:0] a, input logic [31:0] d);
        case (fault_mode)
            1:       return (a == 10'h123) ? (d | 32'h0000_0020) : d;
            2:       return 32'hFFFF_FFFF;
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (v_men && v_wen) mem[v_addr] <= (v_din & v_bm) | (mem[v_addr] & ~v_bm);
        if (v_men && v_ren) mem_dout <= fault_read(v_addr, mem[v_addr]);
    end

    // Expected op stream: {is_write, data, addr}
    function automatic void push_op(input bit w, input bit d, input int a);
        exp_q.push_back({w, d, 10'(a)});
    endfunction

    function automatic void build_march(input int n);
        for (int a = 0; a < n; a++) push_op(1, 0, a);
        for (int a = 0; a < n; a++) begin push_op(0, 0, a); push_op(1, 1, a); end
        for (int a = 0; a < n; a++) begin push_op(0, 1, a); push_op(1, 0, a); end
        for (int a = n - 1; a >= 0; a--) begin push_op(0, 0, a); push_op(1, 1, a); end
        for (int a = n - 1; a >= 0; a--) begin push_op(0, 1, a); push_op(1, 0, a); end
        for (int a = 0; a < n; a++) push_op(0, 0, a);
    endfunction

    // Driver + scoreboard for one run: START in cycle 0, optional extra START, optional reset abort.
    task automatic run_march(input int n, input int ignore_cyc, input int abort_cyc);
        logic [11:0] e;
        logic [79:0] obs, expv;
        exp_q.delete();
        build_march(n);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 1; cyc <= 10 * n + 2; cyc++) begin
            start = (cyc == ignore_cyc);
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                n_vec++;
                if (v_all !== '0 || v_dbg !== ST_IDLE) begin
                    n_err++;
                    $display("FAIL reset_mid_run cyc %0d: outputs %h state %0d, want 0 / IDLE", cyc, v_all, v_dbg);
                end
                exp_q.delete();
                @(negedge clk); rst_n = 1'b1;
                return;
            end
            if (cyc == 1) begin
                n_vec++;
                if ({v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt} !== '0) begin
                    n_err++;
                    $display("FAIL status_cleared_on_start: fail=%0b addr=%h elem=%0d bits=%h cnt=%h, want all 0",
                             v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt);
                end
            end
            if (cyc <= 10 * n) begin
                e    = exp_q.pop_front();
                obs  = {v_men, v_wen, v_ren, v_en, v_busy, v_done, v_addr,
                        e[11] ? v_din : 32'h0, e[11] ? v_bm : 32'h0};
                expv = {1'b1, e[11], ~e[11], 1'b1, 1'b1, 1'b0, e[9:0],
                        e[11] ? {32{e[10]}} : 32'h0, e[11] ? 32'hFFFF_FFFF : 32'h0};
                n_vec++;
                if (obs !== expv) begin
                    n_err++;
                    $display("FAIL op_trace n=%0d cyc %0d: got %h, want %h", n, cyc, obs, expv);
                end
            end else if (cyc == 10 * n + 1) begin
                n_vec++;
                if ({v_men, v_wen, v_ren, v_en, v_busy, v_done} !== 6'b000110 || v_dbg !== ST_DRAIN) begin
                    n_err++;
                    $display("FAIL drain_cycle n=%0d: men/wen/ren/en/busy/done=%b state %0d, want 000110 / DRAIN",
                             n, {v_men, v_wen, v_ren, v_en, v_busy, v_done}, v_dbg);
                end
            end else begin
                n_vec++;
                if ({v_men, v_en, v_busy, v_done} !== 4'b0001) begin
                    n_err++;
                    $display("FAIL done_cycle n=%0d: men/en/busy/done=%b, want 0001",
                             n, {v_men, v_en, v_busy, v_done});
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_vec++;
            if (v_all !== '0 || v_dbg !== ST_IDLE) begin
                n_err++;
                $display("FAIL reset_state dut %0d: outputs %h state %0d, want 0 / IDLE", s, v_all, v_dbg);
            end
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        sel = 0;
        @(negedge clk);
    endtask

    task automatic test_ideal_march();
        sel = 0; fault_mode = 0;
        run_march(1024, 0, 0);
        n_vec++;
        if ({v_fail, v_fail_cnt} !== 9'h0) begin
            n_err++;
            $display("FAIL ideal_status: fail=%0b cnt=%h, want 0/00", v_fail, v_fail_cnt);
        end
    endtask

    task automatic test_small_arrays();
        fault_mode = 0;
        for (int s = 1; s < 3; s++) begin
            sel = s;
            run_march(s == 1 ? 4 : 2, 0, 0);
            n_vec++;
            if ({v_fail, v_fail_cnt} !== 9'h0) begin
                n_err++;
                $display("FAIL small_status dut %0d: fail=%0b cnt=%h, want 0/00", s, v_fail, v_fail_cnt);
            end
        end
        sel = 0;
    endtask

    task automatic test_stuck_bit();
        sel = 0; fault_mode = 1;
        run_march(1024, 0, 0);
        n_vec++;
        if ({v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt} !==
            {1'b1, 10'h123, 3'd1, 32'h0000_0020, 8'd3}) begin
            n_err++;
            $display("FAIL stuck_bit_log: fail=%0b addr=%h elem=%0d bits=%h cnt=%0d, want 1 123 1 00000020 3",
                     v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt);
        end
    endtask

    task automatic test_saturation_ignored_start();
        sel = 0; fault_mode = 2;
        run_march(1024, 100, 0);
        n_vec++;
        if ({v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt} !==
            {1'b1, 10'h000, 3'd1, 32'hFFFF_FFFF, 8'hFF}) begin
            n_err++;
            $display("FAIL saturation_log: fail=%0b addr=%h elem=%0d bits=%h cnt=%h, want 1 000 1 ffffffff ff",
                     v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt);
        end
    endtask

    task automatic test_restart_clears();
        sel = 0; fault_mode = 0;
        run_march(1024, 0, 0);
        n_vec++;
        if ({v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt} !== '0) begin
            n_err++;
            $display("FAIL restart_status: fail=%0b addr=%h elem=%0d bits=%h cnt=%h, want all 0",
                     v_fail, v_fail_addr, v_fail_elem, v_fail_bits, v_fail_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        sel = 0; fault_mode = 0;
        run_march(1024, 0, 500);
        run_march(1024, 0, 0);
        n_vec++;
        if ({v_fail, v_fail_cnt} !== 9'h0) begin
            n_err++;
            $display("FAIL post_reset_status: fail=%0b cnt=%h, want 0/00", v_fail, v_fail_cnt);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        start = 1'b0; sel = 0; fault_mode = 0; rst_n = 1'b0;
        test_reset();
        test_ideal_march();
        test_small_arrays();
        test_stuck_bit();
        test_saturation_ignored_start();
        test_restart_clears();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
